// File: rtl/karatsuba_seq_mult.sv
// karatsuba_seq_mult: one-level Karatsuba multiplier; z0, z2 and mid share one (H+1)x(H+1) multiplier in sequence.
// Define KARATSUBA_SIGNED_EN to add signed_i (two's-complement operands via sign-magnitude around the unsigned core).
module karatsuba_seq_mult #(
  parameter int AWidth    = 131,
  parameter int BWidth    = 127,
  parameter int MulCycles = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [AWidth-1:0]        a_i,
  input  logic [BWidth-1:0]        b_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
`ifdef KARATSUBA_SIGNED_EN
  input  logic                     signed_i,
`endif
  output logic [AWidth+BWidth-1:0] product_o
);
  localparam int MaxW = (AWidth > BWidth) ? AWidth : BWidth;
  localparam int H    = (MaxW + 1) / 2;
  localparam int PW   = AWidth + BWidth;
  localparam logic [3:0] CntLast = 4'(MulCycles - 1);

  typedef enum logic [2:0] {IDLE, MUL_Z0, MUL_Z2, MUL_MID, SUB, COMBINE, RESP} state_e;
  state_e state_q, state_d;

  logic [3:0]     cnt_q, cnt_d;
  logic [2*H-1:0] a_q, a_d, b_q, b_d;
  logic [2*H-1:0] z0_q, z0_d, z2_q, z2_d;
  logic [2*H+1:0] mid_q, mid_d;
  logic [2*H:0]   z1_q, z1_d;
  logic [PW-1:0]  product_q, product_d;
  logic           out_valid_q, out_valid_d;

  logic accept, step_done, in_mul;
  logic z0_we, z2_we, mid_we, z1_we, res_we;

  logic [AWidth-1:0] a_mag;
  logic [BWidth-1:0] b_mag;
  logic [PW-1:0]     res, res_out;

`ifdef KARATSUBA_SIGNED_EN
  logic sign_q, sign_d, sign_in;
  always_comb begin
    a_mag   = a_i;
    b_mag   = b_i;
    sign_in = 1'b0;
    if (signed_i) begin
      if (a_i[AWidth-1]) a_mag = -a_i;
      if (b_i[BWidth-1]) b_mag = -b_i;
      sign_in = a_i[AWidth-1] ^ b_i[BWidth-1];
    end
  end
  assign res_out = sign_q ? -res : res;
`else
  assign a_mag   = a_i;
  assign b_mag   = b_i;
  assign res_out = res;
`endif

  // Shared multiplier: operand pair selected by the current MUL_* state.
  logic [H-1:0] a_hi, a_lo, b_hi, b_lo;
  logic [H:0]   mul_x, mul_y;
  logic [2*H+1:0] mul_p;
  assign a_hi = a_q[2*H-1:H];
  assign a_lo = a_q[H-1:0];
  assign b_hi = b_q[2*H-1:H];
  assign b_lo = b_q[H-1:0];

  always_comb begin
    mul_x = {1'b0, a_hi} + {1'b0, a_lo};
    mul_y = {1'b0, b_hi} + {1'b0, b_lo};
    case (state_q)
      MUL_Z0: begin
        mul_x = {1'b0, a_lo};
        mul_y = {1'b0, b_lo};
      end
      MUL_Z2: begin
        mul_x = {1'b0, a_hi};
        mul_y = {1'b0, b_hi};
      end
      default: ;
    endcase
  end
  assign mul_p = {{(H+1){1'b0}}, mul_x} * {{(H+1){1'b0}}, mul_y};

  // Recombination is done modulo 2^PW; the true product always fits in PW bits.
  assign res = (PW'(z2_q) << (2*H)) + (PW'(z1_q) << H) + PW'(z0_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = MUL_Z0;
      MUL_Z0:  if (step_done)   state_d = MUL_Z2;
      MUL_Z2:  if (step_done)   state_d = MUL_MID;
      MUL_MID: if (step_done)   state_d = SUB;
      SUB:                      state_d = COMBINE;
      COMBINE:                  state_d = RESP;
      RESP:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == IDLE);
    in_mul     = (state_q == MUL_Z0) || (state_q == MUL_Z2) || (state_q == MUL_MID);
    z0_we      = (state_q == MUL_Z0)  && step_done;
    z2_we      = (state_q == MUL_Z2)  && step_done;
    mid_we     = (state_q == MUL_MID) && step_done;
    z1_we      = (state_q == SUB);
    res_we     = (state_q == COMBINE);
  end

  assign accept      = in_valid_i && in_ready_o;
  assign step_done   = (cnt_q == CntLast);
  assign out_valid_o = out_valid_q;
  assign product_o   = product_q;

  always_comb begin
    cnt_d       = 4'd0;
    a_d         = a_q;
    b_d         = b_q;
    z0_d        = z0_q;
    z2_d        = z2_q;
    mid_d       = mid_q;
    z1_d        = z1_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
`ifdef KARATSUBA_SIGNED_EN
    sign_d      = sign_q;
    if (accept) sign_d = sign_in;
`endif
    if (in_mul && !step_done) cnt_d = cnt_q + 4'd1;
    if (accept) begin
      a_d = (2*H)'(a_mag);
      b_d = (2*H)'(b_mag);
    end
    if (z0_we)  z0_d  = mul_p[2*H-1:0];
    if (z2_we)  z2_d  = mul_p[2*H-1:0];
    if (mid_we) mid_d = mul_p;
    if (z1_we)  z1_d  = (2*H+1)'(mid_q - {2'b00, z2_q} - {2'b00, z0_q});
    if (res_we) begin
      product_d   = res_out;
      out_valid_d = 1'b1;
    end
    if (state_q == RESP && out_ready_i) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      z0_q        <= '0;
      z2_q        <= '0;
      mid_q       <= '0;
      z1_q        <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z0_q        <= z0_d;
      z2_q        <= z2_d;
      mid_q       <= mid_d;
      z1_q        <= z1_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
`ifdef KARATSUBA_SIGNED_EN
      sign_q      <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Directed bench for karatsuba_seq_mult: default 131x127 instance plus a MulCycles=3 instance.
module tb_karatsuba_seq_mult;
  localparam int AW = 131;
  localparam int BW = 127;
  localparam int PW = AW + BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_valid3, out_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  wire           in_ready, in_ready3, out_valid, out_valid3;
  wire  [PW-1:0] product, product3;
`ifdef KARATSUBA_SIGNED_EN
  logic          signed_in;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  karatsuba_seq_mult #(.AWidth(AW), .BWidth(BW), .MulCycles(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
`ifdef KARATSUBA_SIGNED_EN
    .signed_i(signed_in),
`endif
    .product_o(product)
  );

  karatsuba_seq_mult #(.AWidth(AW), .BWidth(BW), .MulCycles(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .a_i(a), .b_i(b), .out_valid_o(out_valid3), .out_ready_i(out_ready),
`ifdef KARATSUBA_SIGNED_EN
    .signed_i(signed_in),
`endif
    .product_o(product3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair on the selected instance and count edges until out_valid rises.
  task automatic run_op(input bit use3, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                        output int lat, output logic [PW-1:0] p);
    a = av;
    b = bv;
    if (use3) in_valid3 = 1'b1;
    else      in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    lat = 0;
    while (((use3 ? out_valid3 : out_valid) !== 1'b1) && lat < 60) begin
      tick();
      lat++;
    end
    p = use3 ? product3 : product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b/%b want 0/0", out_valid, out_valid3);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++;
      $display("FAIL reset_product: got %h want 0", product);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b/%b want 1/1", in_ready, in_ready3);
    end
  endtask

  task automatic test_max();
    int lat;
    logic [PW-1:0] p, e;
    e = '0 - (PW'(1) << 131) - (PW'(1) << 127) + PW'(1);
    run_op(1'b0, '1, '1, lat, p);
    tests_run++;
    if (p !== e) begin
      tests_failed++;
      $display("FAIL max_product: got %h want %h", p, e);
    end
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL max_latency: got %0d want 5", lat);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL max_handshake: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_trivial();
    logic [AW-1:0] ta [5];
    logic [BW-1:0] tb [5];
    logic [PW-1:0] te [5];
    logic [PW-1:0] p;
    int lat;
    ta[0] = '0;                         tb[0] = BW'(16'h5A5A);
    te[0] = '0;
    ta[1] = AW'(1);                     tb[1] = (BW'(1) << 126) + BW'(7);
    te[1] = (PW'(1) << 126) + PW'(7);
    ta[2] = AW'(1) << 66;               tb[2] = BW'(1) << 66;
    te[2] = PW'(1) << 132;
    ta[3] = (AW'(1) << 70) + AW'(3);    tb[3] = (BW'(1) << 65) + BW'(5);
    te[3] = (PW'(1) << 135) + (PW'(5) << 70) + (PW'(3) << 65) + PW'(15);
    ta[4] = (AW'(1) << 66) - AW'(1);    tb[4] = '1;
    te[4] = (PW'(1) << 193) - (PW'(1) << 66) - (PW'(1) << 127) + PW'(1);
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ta[i], tb[i], lat, p);
      tests_run++;
      if (p !== te[i] || lat !== 5) begin
        tests_failed++;
        $display("FAIL trivial_%0d: got %h lat %0d want %h lat 5", i, p, lat, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    logic [PW-1:0] p;
    out_ready = 1'b0;
    run_op(1'b0, AW'(7), BW'(9), lat, p);
    tests_run++;
    if (p !== PW'(63) || lat !== 5) begin
      tests_failed++;
      $display("FAIL bp_first: got %h lat %0d want 3f lat 5", p, lat);
    end
    a = AW'(2);
    b = BW'(2);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (product !== PW'(63) || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL bp_hold: product=%h valid=%b ready=%b want 3f/1/0", product, out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next_accept: ready=%b want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    tests_run++;
    if (product !== PW'(4) || lat !== 5) begin
      tests_failed++;
      $display("FAIL bp_second: got %h lat %0d want 4 lat 5", product, lat);
    end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    logic [PW-1:0] p;
    a = AW'(100);
    b = BW'(100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== '0) begin
      tests_failed++;
      $display("FAIL abort_state: valid=%b ready=%b product=%h want 0/1/0", out_valid, in_ready, product);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL abort_no_output: out_valid rose after abort, want 0");
    end
    run_op(1'b0, AW'(3), BW'(5), lat, p);
    tests_run++;
    if (p !== PW'(15) || lat !== 5) begin
      tests_failed++;
      $display("FAIL abort_next_op: got %h lat %0d want f lat 5", p, lat);
    end
    tick();
  endtask

  task automatic test_mulcycles();
    int lat;
    logic [PW-1:0] p, e;
    run_op(1'b1, AW'(3), BW'(5), lat, p);
    tests_run++;
    if (p !== PW'(15) || lat !== 11) begin
      tests_failed++;
      $display("FAIL mc3_small: got %h lat %0d want f lat 11", p, lat);
    end
    tick();
    e = '0 - (PW'(1) << 131) - (PW'(1) << 127) + PW'(1);
    run_op(1'b1, '1, '1, lat, p);
    tests_run++;
    if (p !== e || lat !== 11) begin
      tests_failed++;
      $display("FAIL mc3_max: got %h lat %0d want %h lat 11", p, lat, e);
    end
    tick();
  endtask

`ifdef KARATSUBA_SIGNED_EN
  task automatic test_signed();
    int lat;
    logic [PW-1:0] p, e;
    signed_in = 1'b1;
    e = '0 - PW'(3);
    run_op(1'b0, '1, BW'(3), lat, p);
    tests_run++;
    if (p !== e || lat !== 5) begin
      tests_failed++;
      $display("FAIL signed_neg: got %h lat %0d want %h lat 5", p, lat, e);
    end
    tick();
    e = PW'(1) << 130;
    run_op(1'b0, AW'(1) << 130, '1, lat, p);
    tests_run++;
    if (p !== e || lat !== 5) begin
      tests_failed++;
      $display("FAIL signed_minneg: got %h lat %0d want %h lat 5", p, lat, e);
    end
    tick();
    signed_in = 1'b0;
    e = (PW'(3) << 131) - PW'(3);
    run_op(1'b0, '1, BW'(3), lat, p);
    tests_run++;
    if (p !== e) begin
      tests_failed++;
      $display("FAIL signed_off: got %h want %h", p, e);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
`ifdef KARATSUBA_SIGNED_EN
    signed_in = 1'b0;
`endif
    test_reset();
    test_max();
    test_trivial();
    test_backpressure();
    test_abort();
    test_mulcycles();
`ifdef KARATSUBA_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
